// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: fetch PC, single-outstanding imem read
// handshake, DEPTH-entry prefetch FIFO of {instr, pc+4}, redirect/flush.
//
// state | meaning
// IDLE  | no request in flight; start a fetch when a FIFO slot is free
// REQ   | imem_req high at fetch_pc, waiting for grant
// WAIT  | request granted, waiting for the read data to return
// DROP  | request granted but redirected; discard its returning data
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc4_q   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [31:0]   target;
    logic          room;
    logic          push;
    logic          pop;

    assign target    = redirect_pc & 32'hFFFF_FFFC;
    assign room      = (count < CW'(DEPTH));
    // In WAIT fetch_pc already holds issued_pc + 4; a redirect would have discarded the word.
    assign push      = (state == WAIT) && imem_rvalid && !redirect;
    assign pop       = (count != '0) && id_ready;

    assign imem_req  = (state == REQ);
    assign imem_addr = fetch_pc;
    assign id_valid  = (count != '0);
    assign id_instr  = instr_q[rd_ptr];
    assign id_pc4    = pc4_q[rd_ptr];

    // Fetch sequencer: one request outstanding, slot reserved before issuing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= target;
                    end else if (room) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= target;
                        if (imem_gnt) begin
                            state <= DROP;
                        end
                    end else if (imem_gnt) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc <= target;
                    end
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end else if (redirect) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        fetch_pc <= target;
                    end
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Prefetch FIFO; a redirect empties it and wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc4_q[i]   <= '0;
            end
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= imem_rdata;
                pc4_q[wr_ptr]   <= fetch_pc;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
